// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - command and state encodings shared by the Conway sequencer.
package conway_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_RUN  = 2'd1,
    OP_DUMP = 2'd2,
    OP_RSVD = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down-counter with enable and last-count flag.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the final unit of work so the FSM can leave on the same edge.
  assign last_o = (count_q == W'(1));

endmodule

// File: rtl/conway_sequencer.sv
// rtl/conway_sequencer.sv - LOAD/RUN/DUMP strobe sequencer for the Conway grid memory.
// Optional RUN/DUMP pause input enabled by CONWAY_SEQ_PAUSE_EN.
module conway_sequencer
  import conway_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int GEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [GEN_W-1:0] cmd_gens,
  input  logic             bit_valid,
`ifdef CONWAY_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic             load_mode,
  output logic             run_mode,
  output logic             output_mode,
  output logic             serial_out_valid,
  output logic             done,
  output logic             cmd_err,
  output logic [GEN_W-1:0] gens_done
);

  localparam int BIT_W = $clog2(DATA_SIZE + 1);

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sov_q;
  logic [GEN_W-1:0] gens_q, gens_d;
  logic             bit_load, bit_en, bit_last;
  logic             gen_load, gen_last;
  logic             hold;
  cmd_op_t          op;

  assign op = cmd_op_t'(cmd_op);

`ifdef CONWAY_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    gens_d      = gens_q;
    bit_load    = 1'b0;
    bit_en      = 1'b0;
    gen_load    = 1'b0;
    cmd_ready   = 1'b0;
    load_mode   = 1'b0;
    run_mode    = 1'b0;
    output_mode = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op)
            OP_LOAD: begin
              state_d  = ST_LOAD;
              bit_load = 1'b1;
            end
            OP_RUN: begin
              gens_d = '0;
              // A zero-generation RUN completes without ever leaving IDLE.
              if (cmd_gens == '0) begin
                done_d = 1'b1;
              end else begin
                state_d  = ST_RUN;
                gen_load = 1'b1;
              end
            end
            OP_DUMP: begin
              state_d  = ST_DUMP;
              bit_load = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        load_mode = bit_valid;
        bit_en    = bit_valid;
        if (bit_valid && bit_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          run_mode = 1'b1;
          gens_d   = gens_q + 1'b1;
          if (gen_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DUMP: begin
        if (!hold) begin
          output_mode = 1'b1;
          bit_en      = 1'b1;
          if (bit_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sov_q   <= 1'b0;
      gens_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sov_q   <= output_mode;
      gens_q  <= gens_d;
    end
  end

  seq_down_counter #(.W(BIT_W)) u_bit_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (bit_load),
    .load_val_i (BIT_W'(DATA_SIZE)),
    .en_i       (bit_en),
    .last_o     (bit_last)
  );

  seq_down_counter #(.W(GEN_W)) u_gen_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (gen_load),
    .load_val_i (cmd_gens),
    .en_i       (run_mode),
    .last_o     (gen_last)
  );

  // DRAIN carries the final registered serial bit, so completion lands on it.
  assign done             = done_q | (state_q == ST_DRAIN);
  assign serial_out_valid = sov_q;
  assign cmd_err          = err_q;
  assign gens_done        = gens_q;

endmodule
